fetch_unit: RTL and testbench

Instruction fetch stage of the multi-cycle RISC-V core, directly upstream of the instruction decoder. It owns the program counter, issues one instruction-memory read at a time over a valid/ready request channel, and captures the returned word. It presents the instruction and its PC to decode with a valid/ready handshake. It accepts PC redirects from execute for taken branches, JAL and JALR, and traps misaligned redirect targets into a sticky fault state.

---
 rtl/fetch_unit_if.sv | 49 ++++
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's memory request channel, decode handoff,
// redirect input and fault outputs. The fetch unit sits on the master side.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready,
        input  redirect_valid,
        input  redirect_pc,
        output fetch_fault,
        output fault_pc
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready,
        output redirect_valid,
        output redirect_pc,
        input  fetch_fault,
        input  fault_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one instruction-memory read
// at a time, hands the returned word to decode and follows redirects from
// execute. A misaligned redirect target parks the unit in a sticky fault
// state that only reset clears.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst_n,
    fetch_unit_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] pc;
    logic        discard;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        fetch_fault_q;
    logic [31:0] fault_pc_q;

    logic        req_valid_d;
    logic        instr_valid_d;

    logic        redirect_active;
    logic        redirect_misaligned;
    logic        redirect_aligned;
    logic        req_accept;
    logic        rsp_in_wait;
    logic        capture;
    logic        advance;

    // Event decode shared by the next-state logic and the datapath registers.
    // A redirect only counts in the states that actually fetch.
    always_comb begin
        redirect_active     = bus.redirect_valid &&
                              ((state == S_REQ) || (state == S_WAIT) || (state == S_HOLD));
        redirect_misaligned = redirect_active && (bus.redirect_pc[1:0] != 2'b00);
        redirect_aligned    = redirect_active && (bus.redirect_pc[1:0] == 2'b00);
        req_accept          = (state == S_REQ) && bus.imem_req_ready;
        rsp_in_wait         = (state == S_WAIT) && bus.imem_rsp_valid;
        capture             = rsp_in_wait && !discard && !redirect_active;
        advance             = (state == S_HOLD) && bus.instr_ready && !redirect_active;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; a redirect outranks every other event in the cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                state_next = S_REQ;
            end
            S_REQ: begin
                if (redirect_misaligned) begin
                    state_next = S_FAULT;
                end else if (req_accept) begin
                    state_next = S_WAIT;
                end else begin
                    state_next = S_REQ;
                end
            end
            S_WAIT: begin
                if (redirect_misaligned) begin
                    state_next = S_FAULT;
                end else if (redirect_aligned) begin
                    state_next = bus.imem_rsp_valid ? S_REQ : S_WAIT;
                end else if (bus.imem_rsp_valid) begin
                    state_next = discard ? S_REQ : S_HOLD;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_HOLD: begin
                if (redirect_misaligned) begin
                    state_next = S_FAULT;
                end else if (redirect_aligned || bus.instr_ready) begin
                    state_next = S_REQ;
                end else begin
                    state_next = S_HOLD;
                end
            end
            S_FAULT: begin
                state_next = S_FAULT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Valid outputs are pure decodes of the registered state.
    always_comb begin
        req_valid_d   = 1'b0;
        instr_valid_d = 1'b0;
        unique case (state)
            S_REQ:   req_valid_d   = 1'b1;
            S_HOLD:  instr_valid_d = 1'b1;
            default: begin
                req_valid_d   = 1'b0;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    // PC, discard flag, captured instruction and fault registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc            <= RESET_PC;
            discard       <= 1'b0;
            instr_q       <= 32'h0000_0000;
            instr_pc_q    <= 32'h0000_0000;
            fetch_fault_q <= 1'b0;
            fault_pc_q    <= 32'h0000_0000;
        end else begin
            if (redirect_aligned) begin
                pc <= bus.redirect_pc;
            end else if (advance) begin
                pc <= pc + 32'd4;
            end

            if (redirect_misaligned) begin
                discard <= 1'b0;
            end else if (redirect_aligned && (req_accept || ((state == S_WAIT) && !bus.imem_rsp_valid))) begin
                discard <= 1'b1;
            end else if (rsp_in_wait) begin
                discard <= 1'b0;
            end

            if (capture) begin
                instr_q    <= bus.imem_rsp_data;
                instr_pc_q <= pc;
            end

            if (redirect_misaligned) begin
                fetch_fault_q <= 1'b1;
                fault_pc_q    <= bus.redirect_pc;
            end
        end
    end

    assign bus.imem_req_valid = req_valid_d;
    assign bus.imem_req_addr  = pc;
    assign bus.instr_valid    = instr_valid_d;
    assign bus.instr          = instr_q;
    assign bus.instr_pc       = instr_pc_q;
    assign bus.fetch_fault    = fetch_fault_q;
    assign bus.fault_pc       = fault_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-by-cycle vector table on a unit
// reset to 0x100, plus a hand-written sequence on a second unit reset to
// 0xFFFF_FFFC to exercise PC wrap.
module tb_fetch_unit;

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        redv;
        logic [31:0] redpc;
        logic        rqv;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] ins;
        logic [31:0] ipc;
        logic        ff;
        logic [31:0] fpc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;
    int   checkCount = 0;
    int   passCount  = 0;
    vec_t vecs[$];

    fetch_unit_if bus_a();
    fetch_unit_if bus_b();

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut_a (
        .clk   (clk),
        .rst_n (rst_a_n),
        .bus   (bus_a)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk   (clk),
        .rst_n (rst_b_n),
        .bus   (bus_b)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    function automatic vec_t mk(input int rst, input int rdy, input int rv, input logic [31:0] rd,
                                input int ir, input int redv, input logic [31:0] redpc,
                                input int rqv, input logic [31:0] addr, input int iv,
                                input logic [31:0] ins, input logic [31:0] ipc,
                                input int ff, input logic [31:0] fpc);
        vec_t v;
        v.rst_n = (rst != 0);
        v.rdy   = (rdy != 0);
        v.rv    = (rv != 0);
        v.rd    = rd;
        v.ir    = (ir != 0);
        v.redv  = (redv != 0);
        v.redpc = redpc;
        v.rqv   = (rqv != 0);
        v.addr  = addr;
        v.iv    = (iv != 0);
        v.ins   = ins;
        v.ipc   = ipc;
        v.ff    = (ff != 0);
        v.fpc   = fpc;
        return v;
    endfunction

    task automatic checkBit(input string name, input int idx, input logic actual, input logic expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s step %0d: got %b, want %b", name, idx, actual, expected);
        end
    endtask

    task automatic checkWord(input string name, input int idx, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s step %0d: got %h, want %h", name, idx, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst_a_n              = v.rst_n;
        bus_a.imem_req_ready = v.rdy;
        bus_a.imem_rsp_valid = v.rv;
        bus_a.imem_rsp_data  = v.rd;
        bus_a.instr_ready    = v.ir;
        bus_a.redirect_valid = v.redv;
        bus_a.redirect_pc    = v.redpc;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkBit ("req_valid",   idx, bus_a.imem_req_valid, v.rqv);
        checkWord("req_addr",    idx, bus_a.imem_req_addr,  v.addr);
        checkBit ("instr_valid", idx, bus_a.instr_valid,    v.iv);
        checkWord("instr",       idx, bus_a.instr,          v.ins);
        checkWord("instr_pc",    idx, bus_a.instr_pc,       v.ipc);
        checkBit ("fetch_fault", idx, bus_a.fetch_fault,    v.ff);
        checkWord("fault_pc",    idx, bus_a.fault_pc,       v.fpc);
    endtask

    // One complete fetch on unit B with a ready memory and a one-cycle response.
    task automatic fetchB(input int tag, input logic [31:0] expAddr, input logic [31:0] data);
        int waited = 0;
        bus_b.imem_req_ready = 1'b1;
        while (!bus_b.imem_req_valid && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        checkBit ("wrap_req_valid", tag, bus_b.imem_req_valid, 1'b1);
        checkWord("wrap_req_addr",  tag, bus_b.imem_req_addr,  expAddr);
        @(negedge clk);
        bus_b.imem_req_ready = 1'b0;
        bus_b.imem_rsp_valid = 1'b1;
        bus_b.imem_rsp_data  = data;
        @(negedge clk);
        bus_b.imem_rsp_valid = 1'b0;
        checkBit ("wrap_instr_valid", tag, bus_b.instr_valid, 1'b1);
        checkWord("wrap_instr",       tag, bus_b.instr,       data);
        checkWord("wrap_instr_pc",    tag, bus_b.instr_pc,    expAddr);
        bus_b.instr_ready = 1'b1;
        @(negedge clk);
        bus_b.instr_ready = 1'b0;
    endtask

    initial begin
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        applyStimulus(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        bus_b.imem_req_ready = 1'b0;
        bus_b.imem_rsp_valid = 1'b0;
        bus_b.imem_rsp_data  = 32'h0;
        bus_b.instr_ready    = 1'b0;
        bus_b.redirect_valid = 1'b0;
        bus_b.redirect_pc    = 32'h0;

        // Sequential fetch from 0x100 with one-cycle responses.
        vecs.push_back(mk(1,0,0,0,0,0,0,               0,'h100,0,0,0,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0,               1,'h100,0,0,0,0,0));
        vecs.push_back(mk(1,0,1,'h11111111,0,0,0,      0,'h100,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,1,0,0,               0,'h100,1,'h11111111,'h100,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0,               1,'h104,0,'h11111111,'h100,0,0));
        vecs.push_back(mk(1,0,1,'h22222222,0,0,0,      0,'h104,0,'h11111111,'h100,0,0));
        vecs.push_back(mk(1,0,0,0,1,0,0,               0,'h104,1,'h22222222,'h104,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0,               1,'h108,0,'h22222222,'h104,0,0));
        vecs.push_back(mk(1,0,1,'h33333333,0,0,0,      0,'h108,0,'h22222222,'h104,0,0));
        // Decode backpressure for five cycles.
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(1,0,0,0,0,0,0,           0,'h108,1,'h33333333,'h108,0,0));
        end
        vecs.push_back(mk(1,0,0,0,1,0,0,               0,'h108,1,'h33333333,'h108,0,0));
        // Request held stable while memory is not ready.
        vecs.push_back(mk(1,0,0,0,0,0,0,               1,'h10C,0,'h33333333,'h108,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,               1,'h10C,0,'h33333333,'h108,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0,               1,'h10C,0,'h33333333,'h108,0,0));
        // Redirect in WAIT; late response is dropped.
        vecs.push_back(mk(1,0,0,0,0,1,'h200,           0,'h10C,0,'h33333333,'h108,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,               0,'h200,0,'h33333333,'h108,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,               0,'h200,0,'h33333333,'h108,0,0));
        vecs.push_back(mk(1,0,1,'hDEADBEEF,0,0,0,      0,'h200,0,'h33333333,'h108,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0,               1,'h200,0,'h33333333,'h108,0,0));
        vecs.push_back(mk(1,0,1,'h44444444,0,0,0,      0,'h200,0,'h33333333,'h108,0,0));
        // Redirect in HOLD beats instr_ready.
        vecs.push_back(mk(1,0,0,0,1,1,'h300,           0,'h200,1,'h44444444,'h200,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,               1,'h300,0,'h44444444,'h200,0,0));
        // Redirect in REQ without and with handshake.
        vecs.push_back(mk(1,0,0,0,0,1,'h400,           1,'h300,0,'h44444444,'h200,0,0));
        vecs.push_back(mk(1,1,0,0,0,1,'h500,           1,'h400,0,'h44444444,'h200,0,0));
        vecs.push_back(mk(1,0,1,'h55555555,0,0,0,      0,'h500,0,'h44444444,'h200,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0,               1,'h500,0,'h44444444,'h200,0,0));
        // Redirect together with the response in WAIT.
        vecs.push_back(mk(1,0,1,'h66666666,0,1,'h600,  0,'h500,0,'h44444444,'h200,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0,               1,'h600,0,'h44444444,'h200,0,0));
        vecs.push_back(mk(1,0,1,'h77777777,0,0,0,      0,'h600,0,'h44444444,'h200,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,               0,'h600,1,'h77777777,'h600,0,0));
        // Misaligned redirect: sticky fault, later traffic ignored.
        vecs.push_back(mk(1,0,0,0,0,1,'h202,           0,'h600,1,'h77777777,'h600,0,0));
        vecs.push_back(mk(1,1,1,'h88888888,1,0,0,      0,'h600,0,'h77777777,'h600,1,'h202));
        vecs.push_back(mk(1,0,0,0,0,1,'h700,           0,'h600,0,'h77777777,'h600,1,'h202));
        vecs.push_back(mk(0,0,0,0,0,0,0,               0,'h600,0,'h77777777,'h600,1,'h202));
        vecs.push_back(mk(1,0,0,0,0,0,0,               0,'h100,0,0,0,0,0));
        // Reset during WAIT; the late response must not be captured.
        vecs.push_back(mk(1,1,0,0,0,0,0,               1,'h100,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,               0,'h100,0,0,0,0,0));
        vecs.push_back(mk(1,0,1,'h99999999,0,0,0,      0,'h100,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,               1,'h100,0,0,0,0,0));

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        @(negedge clk);
        rst_b_n = 1'b1;
        checkBit ("wrap_reset_req_valid", 0, bus_b.imem_req_valid, 1'b0);
        checkWord("wrap_reset_addr",      0, bus_b.imem_req_addr,  32'hFFFF_FFFC);
        fetchB(1, 32'hFFFF_FFFC, 32'hAAAA_0001);
        fetchB(2, 32'h0000_0000, 32'hAAAA_0002);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
